// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader: length-prefixed byte stream into 9-bit instruction memory
// Holds the CPU in reset (start=1) while loading, then releases it and watches for halt.
module prog_loader #(
   parameter int MAX_INSTR = 1024,
   parameter int ADDR_W    = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              load_req,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [8:0]        imem_wdata,
   output logic              start,
   input  logic              haltProgram,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, WRITE, RUN, ERR
   } state_t;

   localparam logic [31:0] MAX_U = MAX_INSTR;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [15:0]         len_q, len_d;
   logic [7:0]          lo_byte_q, lo_byte_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [8:0]          imem_wdata_q, imem_wdata_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                xfer;
   logic                last_instr;
   logic [15:0]         len_new;

   always_comb begin
      byte_ready = 1'b0;
      if (!load_req && (state_q == LEN_LO || state_q == LEN_HI ||
                        state_q == INS_LO || state_q == INS_HI))
         byte_ready = 1'b1;
   end

   assign xfer       = byte_valid && byte_ready;
   assign len_new    = {byte_in, lo_byte_q};
   assign last_instr = (32'(cnt_q) + 32'd1) == 32'(len_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      lo_byte_d    = lo_byte_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      start_d      = start_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;

      // A restart request overrides whatever state we are in; a WRITE already on the bus still completes.
      if (load_req) begin
         state_d = LEN_LO;
         cnt_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b0;
         start_d = 1'b1;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            LEN_LO: begin
               if (xfer) begin
                  lo_byte_d = byte_in;
                  state_d   = LEN_HI;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_d = len_new;
                  if (len_new == 16'd0 || 32'(len_new) > MAX_U) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                     busy_d  = 1'b0;
                     start_d = 1'b1;
                  end else begin
                     state_d = INS_LO;
                  end
               end
            end
            INS_LO: begin
               if (xfer) begin
                  lo_byte_d = byte_in;
                  state_d   = INS_HI;
               end
            end
            INS_HI: begin
               if (xfer) begin
                  if (byte_in[7:1] != 7'd0) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                     busy_d  = 1'b0;
                     start_d = 1'b1;
                  end else begin
                     state_d      = WRITE;
                     imem_we_d    = 1'b1;
                     imem_addr_d  = cnt_q;
                     imem_wdata_d = {byte_in[0], lo_byte_q};
                  end
               end
            end
            WRITE: begin
               cnt_d = cnt_q + 1'b1;
               if (last_instr) begin
                  state_d = RUN;
                  start_d = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  state_d = INS_LO;
               end
            end
            RUN: begin
               if (haltProgram) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  start_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         len_q        <= '0;
         lo_byte_q    <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         start_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         lo_byte_q    <= lo_byte_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign start      = start_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven cycle vectors for prog_loader plus async reset sequence
// Each vector: inputs driven at negedge, byte_ready checked before the edge, registered outputs after it.
module tb_prog_loader;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        load_req, byte_valid, haltProgram;
   logic [7:0]  byte_in;
   logic        byte_ready, imem_we, start, busy, done, err;
   logic [15:0] imem_addr;
   logic [8:0]  imem_wdata;

   int checks = 0;
   int failures = 0;

   prog_loader #(.MAX_INSTR(1024), .ADDR_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .load_req(load_req), .byte_valid(byte_valid),
      .byte_in(byte_in), .byte_ready(byte_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .start(start),
      .haltProgram(haltProgram), .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        lr, bv;
      logic [7:0]  b;
      logic        h;
      logic        rdy, we;
      logic [15:0] a;
      logic [8:0]  wd;
      logic        st, bs, dn, er;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic lr, input logic bv, input logic [7:0] b, input logic h,
                      input logic rdy, input logic we, input logic [15:0] a, input logic [8:0] wd,
                      input logic st, input logic bs, input logic dn, input logic er);
      vec_t v;
      v.lr = lr; v.bv = bv; v.b = b; v.h = h;
      v.rdy = rdy; v.we = we; v.a = a; v.wd = wd;
      v.st = st; v.bs = bs; v.dn = dn; v.er = er;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic we, input logic [15:0] a, input logic [8:0] wd,
                          input logic st, input logic bs, input logic dn, input logic er);
      chk("imem_we", idx, 32'(imem_we), 32'(we));
      chk("imem_addr", idx, 32'(imem_addr), 32'(a));
      chk("imem_wdata", idx, 32'(imem_wdata), 32'(wd));
      chk("start", idx, 32'(start), 32'(st));
      chk("busy", idx, 32'(busy), 32'(bs));
      chk("done", idx, 32'(done), 32'(dn));
      chk("err", idx, 32'(err), 32'(er));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_N = 1'b0; load_req = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; haltProgram = 1'b0;

      // Three-instruction load, run, halt
      add(1,0,8'h00,0, 0,0,16'd0,9'h000,1,1,0,0);
      add(0,1,8'h03,0, 1,0,16'd0,9'h000,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h000,1,1,0,0);
      add(0,1,8'h2A,0, 1,0,16'd0,9'h000,1,1,0,0);
      add(0,1,8'h00,0, 1,1,16'd0,9'h02A,1,1,0,0);
      add(0,0,8'h00,0, 0,0,16'd0,9'h02A,1,1,0,0);
      add(0,1,8'hFF,0, 1,0,16'd0,9'h02A,1,1,0,0);
      add(0,1,8'h01,0, 1,1,16'd1,9'h1FF,1,1,0,0);
      add(0,0,8'h00,0, 0,0,16'd1,9'h1FF,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd1,9'h1FF,1,1,0,0);
      add(0,1,8'h01,0, 1,1,16'd2,9'h100,1,1,0,0);
      add(0,0,8'h00,0, 0,0,16'd2,9'h100,0,0,0,0);
      add(0,1,8'h55,0, 0,0,16'd2,9'h100,0,0,0,0);
      add(0,0,8'h00,1, 0,0,16'd2,9'h100,0,0,1,0);
      add(0,0,8'h00,0, 0,0,16'd2,9'h100,0,0,1,0);
      // Reload with byte_valid high alongside load_req, and stalls between bytes
      add(1,1,8'h07,0, 0,0,16'd2,9'h100,1,1,0,0);
      add(0,1,8'h01,0, 1,0,16'd2,9'h100,1,1,0,0);
      for (int i = 0; i < 5; i++) add(0,0,8'hEE,0, 1,0,16'd2,9'h100,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd2,9'h100,1,1,0,0);
      for (int i = 0; i < 2; i++) add(0,0,8'hEE,0, 1,0,16'd2,9'h100,1,1,0,0);
      add(0,1,8'h33,0, 1,0,16'd2,9'h100,1,1,0,0);
      for (int i = 0; i < 5; i++) add(0,0,8'hFE,0, 1,0,16'd2,9'h100,1,1,0,0);
      add(0,1,8'h01,0, 1,1,16'd0,9'h133,1,1,0,0);
      add(0,0,8'h00,0, 0,0,16'd0,9'h133,0,0,0,0);
      // Zero count, then N=1025
      add(1,0,8'h00,0, 0,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h133,1,0,0,1);
      add(0,1,8'hAA,0, 0,0,16'd0,9'h133,1,0,0,1);
      add(1,0,8'h00,0, 0,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h01,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h04,0, 1,0,16'd0,9'h133,1,0,0,1);
      // N=1024 is accepted, then a bad high byte
      add(1,0,8'h00,0, 0,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h04,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h11,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h02,0, 1,0,16'd0,9'h133,1,0,0,1);
      add(0,0,8'h00,0, 0,0,16'd0,9'h133,1,0,0,1);
      add(1,0,8'h00,0, 0,0,16'd0,9'h133,1,1,0,0);
      add(0,0,8'h00,0, 1,0,16'd0,9'h133,1,1,0,0);
      // load_req on the edge that finishes a WRITE of the last instruction
      add(0,1,8'h01,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h44,0, 1,0,16'd0,9'h133,1,1,0,0);
      add(0,1,8'h00,0, 1,1,16'd0,9'h044,1,1,0,0);
      add(1,0,8'h00,0, 0,0,16'd0,9'h044,1,1,0,0);
      add(0,0,8'h00,0, 1,0,16'd0,9'h044,1,1,0,0);
      // Walk into a WRITE for the async reset test
      add(0,1,8'h01,0, 1,0,16'd0,9'h044,1,1,0,0);
      add(0,1,8'h00,0, 1,0,16'd0,9'h044,1,1,0,0);
      add(0,1,8'h12,0, 1,0,16'd0,9'h044,1,1,0,0);
      add(0,1,8'h01,0, 1,1,16'd0,9'h112,1,1,0,0);

      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ready", -1, 32'(byte_ready), 32'd0);
      chk_all(-1, 0, 16'd0, 9'h000, 1, 0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge CLK);
         load_req = vq[i].lr; byte_valid = vq[i].bv; byte_in = vq[i].b; haltProgram = vq[i].h;
         #1;
         chk("byte_ready", i, 32'(byte_ready), 32'(vq[i].rdy));
         @(posedge CLK);
         #1;
         chk_all(i, vq[i].we, vq[i].a, vq[i].wd, vq[i].st, vq[i].bs, vq[i].dn, vq[i].er);
      end

      // Asynchronous reset in the middle of a WRITE cycle, clock not involved
      load_req = 1'b0; byte_valid = 1'b1; byte_in = 8'h00;
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_ready", -2, 32'(byte_ready), 32'd0);
      chk_all(-2, 0, 16'd0, 9'h000, 1, 0, 0, 0);
      @(posedge CLK);
      #1;
      chk_all(-3, 0, 16'd0, 9'h000, 1, 0, 0, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      byte_valid = 1'b1;
      #1;
      chk("post_rst_ready", -4, 32'(byte_ready), 32'd0);
      @(posedge CLK);
      #1;
      chk_all(-4, 0, 16'd0, 9'h000, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
